// File: rtl/localbp_initctl_if.sv
// rtl/localbp_initctl_if.sv - update-request and SRAM write-port bundle for localbp_initctl
interface localbp_initctl_if #(
  parameter int M = 6,
  parameter int K = 10
);
  // W-stage update requests from the predictor
  logic         StallW;
  logic         FlushW;
  logic         UpdPHTWe;
  logic [K-1:0] UpdPHTAddr;
  logic [1:0]   UpdPHTData;
  logic         UpdBHTWe;
  logic [M-1:0] UpdBHTAddr;
  logic [K-1:0] UpdBHTData;
  logic         FlushReq;

  // SRAM port-2 write pins and status back to fetch/update logic
  logic         PHTCe;
  logic         PHTWe;
  logic [K-1:0] PHTAddr;
  logic [1:0]   PHTData;
  logic         BHTCe;
  logic         BHTWe;
  logic [M-1:0] BHTAddr;
  logic [K-1:0] BHTData;
  logic         InitBusy;
  logic         FlushAck;
  logic         UpdDrop;

  modport master (
    output StallW, FlushW, UpdPHTWe, UpdPHTAddr, UpdPHTData,
           UpdBHTWe, UpdBHTAddr, UpdBHTData, FlushReq,
    input  PHTCe, PHTWe, PHTAddr, PHTData,
           BHTCe, BHTWe, BHTAddr, BHTData,
           InitBusy, FlushAck, UpdDrop
  );

  modport slave (
    input  StallW, FlushW, UpdPHTWe, UpdPHTAddr, UpdPHTData,
           UpdBHTWe, UpdBHTAddr, UpdBHTData, FlushReq,
    output PHTCe, PHTWe, PHTAddr, PHTData,
           BHTCe, BHTWe, BHTAddr, BHTData,
           InitBusy, FlushAck, UpdDrop
  );
endinterface

// File: rtl/localbp_initctl.sv
// rtl/localbp_initctl.sv - BHT/PHT init sweep sequencer and write-port arbiter (optional flush: LOCALBP_FLUSH_EN)
module localbp_initctl #(
  parameter int M = 6,
  parameter int K = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  localbp_initctl_if.slave bus
);

  localparam logic [0:0]   ST_INIT  = 1'b0;
  localparam logic [0:0]   ST_READY = 1'b1;
  localparam logic [K-1:0] CNT_MAX  = {K{1'b1}};
  // Weakly-not-taken encoding of the 2-bit PHT counter
  localparam logic [1:0]   PHT_INIT = 2'b01;

  logic [0:0]   state_q, state_d;
  logic [K-1:0] cnt_q, cnt_d;
  logic         src_q, src_d;
  logic         ack_q, ack_d;

  logic         upd_qual;
  logic         bht_in_range;
  logic         flush_take;

  // An update only counts when the W stage is neither stalled nor flushed
  assign upd_qual     = ~bus.StallW & ~bus.FlushW;
  // BHT is shallower than PHT; only the first 2^M sweep counts touch it
  assign bht_in_range = ((cnt_q >> M) == '0);

`ifdef LOCALBP_FLUSH_EN
  // Requests are ignored in the ack cycle so a still-held FlushReq cannot retrigger
  assign flush_take   = bus.FlushReq & ~ack_q;
  assign bus.FlushAck = ack_q;
`else
  logic unused_cfg;
  assign flush_take   = 1'b0;
  assign bus.FlushAck = 1'b0;
  assign unused_cfg   = ^{bus.FlushReq, ack_q};
`endif

  // Next-state: sweep counter runs through the whole PHT, then hands over to READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_READY;
          cnt_d   = '0;
          ack_d   = src_q;
          src_d   = 1'b0;
        end
      end
      ST_READY: begin
        if (flush_take) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          src_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        src_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any pending flush without acknowledging it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
    end
  end

  // Write-port mux: sweep owns both ports in INIT, updates pass straight through in READY
  always_comb begin
    bus.PHTCe    = 1'b0;
    bus.PHTWe    = 1'b0;
    bus.PHTAddr  = '0;
    bus.PHTData  = '0;
    bus.BHTCe    = 1'b0;
    bus.BHTWe    = 1'b0;
    bus.BHTAddr  = '0;
    bus.BHTData  = '0;
    bus.InitBusy = 1'b1;
    bus.UpdDrop  = 1'b0;
    if (state_q == ST_INIT) begin
      bus.PHTCe    = 1'b1;
      bus.PHTWe    = 1'b1;
      bus.PHTAddr  = cnt_q;
      bus.PHTData  = PHT_INIT;
      bus.BHTCe    = 1'b1;
      bus.BHTWe    = bht_in_range;
      bus.BHTAddr  = cnt_q[M-1:0];
      bus.BHTData  = '0;
      bus.InitBusy = 1'b1;
      bus.UpdDrop  = upd_qual & (bus.UpdPHTWe | bus.UpdBHTWe);
    end else begin
      bus.PHTCe    = upd_qual;
      bus.PHTWe    = bus.UpdPHTWe;
      bus.PHTAddr  = bus.UpdPHTAddr;
      bus.PHTData  = bus.UpdPHTData;
      bus.BHTCe    = upd_qual;
      bus.BHTWe    = bus.UpdBHTWe;
      bus.BHTAddr  = bus.UpdBHTAddr;
      bus.BHTData  = bus.UpdBHTData;
      bus.InitBusy = 1'b0;
      bus.UpdDrop  = 1'b0;
    end
  end

endmodule
